fifo_msg_sequencer: RTL and testbench

//   Sequences a null-terminated message from a synchronous byte ROM into the fifo_uart write port.
//   On a start pulse it copies the selected message slot byte by byte, honouring FIFO full.
//   It sits between trigger logic (buttons or timer) and fifo_uart, replacing free-running counter fills.

---
 rtl/fifo_msg_sequencer.sv | 136 +++++++++++++
 tb/tb_fifo_msg_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_msg_sequencer.sv
// fifo_msg_sequencer: copies a null-terminated message from a synchronous byte ROM into a FIFO write port.
//
// Ports:
//   clk_i       clock, all logic on posedge
//   rst_i       asynchronous active-high reset
//   start_i     start request, sampled only while idle
//   sel_i       message slot, latched with start_i
//   rom_addr_o  registered ROM address ({slot, offset})
//   rom_data_i  ROM data, valid one clock after rom_addr_o changes
//   full_i      FIFO full flag
//   byte_o      registered byte to the FIFO
//   wren_o      FIFO write strobe, one-clock pulse per byte
//   busy_o      high whenever not idle
//   done_o      one-clock pulse when a message completes
//   trunc_o     sticky: last message reached the slot end without a null
//
// Build option: define APPEND_CRLF_EN to append 0x0D 0x0A after every message.
module fifo_msg_sequencer #(
    parameter int AW   = 8,
    parameter int SELW = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [SELW-1:0] sel_i,
    output logic [AW-1:0]   rom_addr_o,
    input  logic [7:0]      rom_data_i,
    input  logic            full_i,
    output logic [7:0]      byte_o,
    output logic            wren_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            trunc_o
);
    localparam int OW = AW - SELW;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef APPEND_CRLF_EN
    localparam logic [2:0] S_TAIL  = 3'd4;
    // GAP gives the FIFO one clock to reflect the previous write in full_i
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] NULL_NEXT  = S_TAIL;
    localparam logic [2:0] TRUNC_NEXT = S_GAP;
`else
    localparam logic [2:0] NULL_NEXT  = S_DONE;
    localparam logic [2:0] TRUNC_NEXT = S_DONE;
`endif

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    byte_q, byte_d;
    logic          wren_q, wren_d;
    logic          trunc_q, trunc_d;
`ifdef APPEND_CRLF_EN
    logic [1:0]    tail_q, tail_d;
`endif

    // The upper address bits hold the latched slot; the lower OW bits are the offset counter.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        wren_d  = 1'b0;
        trunc_d = trunc_q;
`ifdef APPEND_CRLF_EN
        tail_d  = tail_q;
`endif
        case (state_q)
            S_IDLE: if (start_i) begin
                addr_d  = {sel_i, {OW{1'b0}}};
                trunc_d = 1'b0;
`ifdef APPEND_CRLF_EN
                tail_d  = 2'd0;
`endif
                state_d = S_FETCH;
            end
            S_FETCH: state_d = S_CHECK;
            S_CHECK: if (rom_data_i == 8'h00) begin
                state_d = NULL_NEXT;
            end else if (!full_i) begin
                byte_d = rom_data_i;
                wren_d = 1'b1;
                if (&addr_q[OW-1:0]) begin
                    trunc_d = 1'b1;
                    state_d = TRUNC_NEXT;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
`ifdef APPEND_CRLF_EN
            S_TAIL: if (!full_i) begin
                byte_d  = tail_q[0] ? 8'h0A : 8'h0D;
                wren_d  = 1'b1;
                tail_d  = tail_q + 2'd1;
                state_d = S_GAP;
            end
            S_GAP: state_d = tail_q[1] ? S_DONE : S_TAIL;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            byte_q  <= '0;
            wren_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            wren_q  <= wren_d;
            trunc_q <= trunc_d;
        end
    end

`ifdef APPEND_CRLF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tail_q <= 2'd0;
        else       tail_q <= tail_d;
    end
`endif

    assign rom_addr_o = addr_q;
    assign byte_o     = byte_q;
    assign wren_o     = wren_q;
    assign trunc_o    = trunc_q;
    assign busy_o     = state_q != S_IDLE;
    assign done_o     = state_q == S_DONE;
endmodule

// File: tb/tb_fifo_msg_sequencer.sv
// tb_fifo_msg_sequencer: directed and randomized bench for fifo_msg_sequencer with a message-level reference model.
module tb_fifo_msg_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [1:0] sel_i = 2'd0;
    logic [7:0] rom_addr_o;
    logic [7:0] rom_data_i = 8'h00;
    logic       full_i = 1'b0;
    logic [7:0] byte_o;
    logic       wren_o, busy_o, done_o, trunc_o;

    logic [7:0] rom [256];
    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int wr_cyc[$];
    int done_k, wr_bad, addr_bad, seen;
    logic tr_start, exp_tr;
    logic [7:0] first_addr;

    fifo_msg_sequencer #(.AW(8), .SELW(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sel_i(sel_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .full_i(full_i),
        .byte_o(byte_o), .wren_o(wren_o), .busy_o(busy_o), .done_o(done_o), .trunc_o(trunc_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected write stream: slot bytes up to the first null or the 64-byte slot end, then optional CRLF.
    task automatic model(input int sel);
        int base;
        base = sel * 64;
        exp_q.delete();
        exp_tr = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (rom[base + i] == 8'h00) break;
            exp_q.push_back(rom[base + i]);
            if (i == 63) exp_tr = 1'b1;
        end
`ifdef APPEND_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // mode 0: never full; 1: random full; 2: full held 10 clk after the first write
    task automatic run_msg(input int sel, input int mode, input bit poke);
        int hold;
        logic fp;
        got_q.delete();
        wr_cyc.delete();
        done_k = -1;
        wr_bad = 0;
        addr_bad = 0;
        hold = 0;
        sel_i = 2'(sel);
        start_i = 1'b1;
        full_i = 1'b0;
        for (int k = 1; k <= 600 && done_k < 0; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            fp = full_i;
            start_i = poke && k == 2;
            sel_i = (poke && k == 2) ? 2'd2 : 2'(sel);
            if (k == 1) begin
                tr_start = trunc_o;
                first_addr = rom_addr_o;
            end
            if (wren_o) begin
                got_q.push_back(byte_o);
                wr_cyc.push_back(k);
                if (fp) wr_bad++;
            end
            if (busy_o && int'(rom_addr_o[7:6]) != sel) addr_bad++;
            if (done_o) done_k = k;
            if (mode == 2) begin
                if (wren_o && wr_cyc.size() == 1) hold = 10;
                full_i = hold > 0;
                if (hold > 0) hold--;
            end else begin
                full_i = (mode == 1) && ($urandom_range(0, 2) == 0);
            end
        end
        start_i = 1'b0;
        full_i = 1'b0;
    endtask

    task automatic verify(input string t);
        chk({t, "_done_seen"}, done_k > 0, 1);
        chk({t, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", t, i), got_q[i], exp_q[i]);
        chk({t, "_trunc"}, trunc_o, exp_tr);
        chk({t, "_trunc_cleared_on_start"}, tr_start, 0);
        chk({t, "_wren_while_full"}, wr_bad, 0);
        chk({t, "_addr_outside_slot"}, addr_bad, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk({t, "_busy_after_done"}, busy_o, 0);
        chk({t, "_done_single_pulse"}, done_o, 0);
        chk({t, "_trunc_sticky"}, trunc_o, exp_tr);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[64] = 8'h48;
        rom[65] = 8'h49;
        for (int i = 128; i < 192; i++) rom[i] = 8'($urandom_range(1, 255));

        // power-on reset
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("por_outputs", {rom_addr_o, byte_o, wren_o, busy_o, done_o, trunc_o}, 0);
        rst_i = 1'b0;

        // reset asserted mid-message
        sel_i = 2'd1;
        start_i = 1'b1;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            start_i = 1'b0;
            if (wren_o) seen = 1;
        end
        chk("rst_pre_wren_seen", seen, 1);
        #2 rst_i = 1'b1;
        #1 chk("rst_async_outputs", {rom_addr_o, byte_o, wren_o, busy_o, done_o, trunc_o}, 0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (busy_o || wren_o || done_o) seen++;
        end
        chk("rst_no_resume", seen, 0);

        // "HI" from slot 1, with an ignored start pulse while busy
        model(1);
        run_msg(1, 0, 1);
        chk("hi_first_addr", first_addr, 8'h40);
        chk("hi_write_spacing", wr_cyc.size() > 1 ? wr_cyc[1] - wr_cyc[0] : -1, 2);
        chk("hi_first_write_clk", wr_cyc.size() > 0 ? wr_cyc[0] : -1, 3);
`ifdef APPEND_CRLF_EN
        chk("hi_done_clk", done_k, 11);
`else
        chk("hi_done_clk", done_k, 7);
`endif
        verify("hi");
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (busy_o || wren_o) seen++;
        end
        chk("hi_start_not_queued", seen, 0);

        // same message with full_i held high after the first write
        model(1);
        run_msg(1, 2, 0);
        chk("stall_second_write_clk", wr_cyc.size() > 1 ? wr_cyc[1] : -1, 14);
        verify("stall");

        // empty message in slot 0
        model(0);
        run_msg(0, 0, 0);
`ifdef APPEND_CRLF_EN
        chk("empty_done_clk", done_k, 7);
`else
        chk("empty_done_clk", done_k, 3);
`endif
        verify("empty");

        // full slot without a null
        model(2);
        run_msg(2, 0, 0);
        verify("trunc");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("trunc_held_idle", trunc_o, 1);

        // random messages with random backpressure
        for (int r = 0; r < 16; r++) begin
            int sel, len;
            sel = $urandom_range(0, 3);
            len = $urandom_range(0, 66);
            for (int i = 0; i < 64; i++)
                rom[sel * 64 + i] = (i < len) ? 8'($urandom_range(1, 255)) : 8'h00;
            model(sel);
            run_msg(sel, 1, 0);
            verify($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
